// File: rtl/serial_word_feeder_if.sv
// Load handshake and serial output bundle for serial_word_feeder.
// master: the word source (drives the word, sees the serial stream).
// slave : the feeder itself.
interface serial_word_feeder_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] data_in;
  logic             load_valid;
  logic             load_ready;
  logic             ser_out;
  logic             ser_valid;
  logic             frame_start;
  logic             frame_end;

  modport master (
    output data_in,
    output load_valid,
    input  load_ready,
    input  ser_out,
    input  ser_valid,
    input  frame_start,
    input  frame_end
  );

  modport slave (
    input  data_in,
    input  load_valid,
    output load_ready,
    output ser_out,
    output ser_valid,
    output frame_start,
    output frame_end
  );
endinterface

// File: rtl/serial_word_feeder.sv
// Parallel-to-serial front end for the bit-serial pattern detector.
// Takes WIDTH-bit words over valid/ready and emits one bit per clock.
// A new word may be accepted on the last bit of the current one, so
// streamed words follow each other with no gap bit. Outside a frame the
// serial line is held at 0.
module serial_word_feeder #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  serial_word_feeder_if.slave bus
);

  localparam int              CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]   CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0]   CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    cnt;

  logic             ser_out_p0;
  logic             vld_p0;
  logic             sof_p0;
  logic             eof_p0;

  logic             accept;

  // Bit that sits at the output end of a shift register image.
  function automatic logic out_bit(input logic [WIDTH-1:0] s);
    return MSB_FIRST ? s[WIDTH-1] : s[0];
  endfunction

  // Move the word one place toward the output end, filling with 0.
  function automatic logic [WIDTH-1:0] shift_once(input logic [WIDTH-1:0] s);
    return MSB_FIRST ? {s[WIDTH-2:0], 1'b0} : {1'b0, s[WIDTH-1:1]};
  endfunction

  // Ready while idle or on the last bit of a frame; never during reset.
  assign bus.load_ready = reset && ((state == IDLE) || ((state == SHIFT) && (cnt == '0)));
  assign accept         = bus.load_valid && bus.load_ready;

  // Word FSM: load, shift and idle, with the serial outputs registered
  // from the same next-state decision so they line up with shreg/cnt.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      shreg      <= '0;
      cnt        <= '0;
      ser_out_p0 <= 1'b0;
      vld_p0     <= 1'b0;
      sof_p0     <= 1'b0;
      eof_p0     <= 1'b0;
    end else begin
      case (state)
        IDLE, SHIFT: begin
          if (accept) begin
            state      <= SHIFT;
            shreg      <= bus.data_in;
            cnt        <= CNT_LAST;
            ser_out_p0 <= out_bit(bus.data_in);
            vld_p0     <= 1'b1;
            sof_p0     <= 1'b1;
            eof_p0     <= 1'b0;
          end else if ((state == SHIFT) && (cnt != '0)) begin
            shreg      <= shift_once(shreg);
            cnt        <= cnt - 1'b1;
            ser_out_p0 <= out_bit(shift_once(shreg));
            vld_p0     <= 1'b1;
            sof_p0     <= 1'b0;
            eof_p0     <= (cnt == CNT_ONE);
          end else begin
            state      <= IDLE;
            shreg      <= '0;
            cnt        <= '0;
            ser_out_p0 <= 1'b0;
            vld_p0     <= 1'b0;
            sof_p0     <= 1'b0;
            eof_p0     <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          shreg      <= '0;
          cnt        <= '0;
          ser_out_p0 <= 1'b0;
          vld_p0     <= 1'b0;
          sof_p0     <= 1'b0;
          eof_p0     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ser_out     = ser_out_p0;
  assign bus.ser_valid   = vld_p0;
  assign bus.frame_start = sof_p0;
  assign bus.frame_end   = eof_p0;

endmodule

// File: tb/tb_serial_word_feeder.sv
// Directed bench for serial_word_feeder: reset, single word, streaming,
// ignored loads, LSB-first ordering and mid-frame reset.
module tb_serial_word_feeder;

  logic clk;
  logic reset;

  int checks = 0;
  int errors = 0;

  serial_word_feeder_if #(.WIDTH(8)) bus0 ();
  serial_word_feeder_if #(.WIDTH(8)) bus1 ();

  serial_word_feeder #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0.slave)
  );

  serial_word_feeder #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // {ser_out, ser_valid, frame_start, frame_end, load_ready}
  function automatic logic [4:0] outs0();
    return {bus0.ser_out, bus0.ser_valid, bus0.frame_start, bus0.frame_end, bus0.load_ready};
  endfunction

  function automatic logic [4:0] outs1();
    return {bus1.ser_out, bus1.ser_valid, bus1.frame_start, bus1.frame_end, bus1.load_ready};
  endfunction

  logic [15:0] so, sv, fs, fe, rdy;
  int          vld_seen;

  initial begin
    reset           = 1'b0;
    bus0.data_in    = '0;
    bus0.load_valid = 1'b0;
    bus1.data_in    = '0;
    bus1.load_valid = 1'b0;

    // Reset held for two cycles
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("reset_outs_msb", 32'(outs0()), 32'h0);
    chk("reset_outs_lsb", 32'(outs1()), 32'h0);
    reset = 1'b1;
    @(negedge clk);
    chk("idle_after_reset", 32'(outs0()), 32'h01);

    // Single word 8'hC3, MSB first
    bus0.data_in    = 8'hC3;
    bus0.load_valid = 1'b1;
    so = '0; sv = '0; fs = '0; fe = '0; rdy = '0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      so[7-i] = bus0.ser_out;  sv[7-i] = bus0.ser_valid;
      fs[7-i] = bus0.frame_start; fe[7-i] = bus0.frame_end;
      rdy[7-i] = bus0.load_ready;
      if (i == 0) bus0.load_valid = 1'b0;
    end
    chk("single_ser_out", 32'(so[7:0]), 32'hC3);
    chk("single_ser_valid", 32'(sv[7:0]), 32'hFF);
    chk("single_frame_start", 32'(fs[7:0]), 32'h80);
    chk("single_frame_end", 32'(fe[7:0]), 32'h01);
    chk("single_load_ready", 32'(rdy[7:0]), 32'h01);
    @(negedge clk);
    chk("single_return_idle", 32'(outs0()), 32'h01);

    // Back-to-back 8'hA5 then 8'h0F with load_valid held
    bus0.data_in    = 8'hA5;
    bus0.load_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      so[15-i] = bus0.ser_out;  sv[15-i] = bus0.ser_valid;
      fs[15-i] = bus0.frame_start; fe[15-i] = bus0.frame_end;
      if (i == 0) bus0.data_in = 8'h0F;
      if (i == 8) bus0.load_valid = 1'b0;
    end
    chk("b2b_ser_out", 32'(so), 32'hA50F);
    chk("b2b_ser_valid", 32'(sv), 32'hFFFF);
    chk("b2b_frame_start", 32'(fs), 32'h8080);
    chk("b2b_frame_end", 32'(fe), 32'h0101);
    @(negedge clk);
    chk("b2b_return_idle", 32'(outs0()), 32'h01);

    // 8'hFF presented mid-frame of 8'h00 is only taken on the last bit
    bus0.data_in    = 8'h00;
    bus0.load_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      so[15-i] = bus0.ser_out; sv[15-i] = bus0.ser_valid;
      rdy[15-i] = bus0.load_ready;
      if (i == 0) bus0.data_in = 8'hFF;
      if (i == 8) bus0.load_valid = 1'b0;
    end
    chk("ignored_ser_out", 32'(so), 32'h00FF);
    chk("ignored_ser_valid", 32'(sv), 32'hFFFF);
    chk("ignored_load_ready", 32'(rdy), 32'h0101);
    @(negedge clk);
    chk("ignored_return_idle", 32'(outs0()), 32'h01);

    // LSB-first instance, 8'h01
    bus1.data_in    = 8'h01;
    bus1.load_valid = 1'b1;
    so = '0; fs = '0; fe = '0; sv = '0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      so[7-i] = bus1.ser_out; sv[7-i] = bus1.ser_valid;
      fs[7-i] = bus1.frame_start; fe[7-i] = bus1.frame_end;
      if (i == 0) bus1.load_valid = 1'b0;
    end
    chk("lsb_ser_out", 32'(so[7:0]), 32'h80);
    chk("lsb_ser_valid", 32'(sv[7:0]), 32'hFF);
    chk("lsb_frame_start", 32'(fs[7:0]), 32'h80);
    chk("lsb_frame_end", 32'(fe[7:0]), 32'h01);
    @(negedge clk);
    chk("lsb_return_idle", 32'(outs1()), 32'h01);

    // Reset asserted during bit 4 of 8'hFF
    bus0.data_in    = 8'hFF;
    bus0.load_valid = 1'b1;
    so = '0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      so[3-i] = bus0.ser_out;
      if (i == 0) bus0.load_valid = 1'b0;
    end
    chk("midreset_first_bits", 32'(so[3:0]), 32'hF);
    reset = 1'b0;
    #1;
    chk("midreset_async_outs", 32'(outs0()), 32'h0);
    @(negedge clk);
    chk("midreset_held_outs", 32'(outs0()), 32'h0);
    reset = 1'b1;
    vld_seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus0.ser_valid || bus0.ser_out) vld_seen++;
    end
    chk("midreset_no_residual", 32'(vld_seen), 32'h0);
    chk("midreset_idle", 32'(outs0()), 32'h01);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
